// File: rtl/uart_word_link_pkg.sv
// Shared constants, baud divider derivation and FSM state types for the UART word link.
package uart_word_link_pkg;

  localparam int FRAME_BITS = 11;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte deframer: Rx synchronizer, mid-bit sampling and parity check.
module uart_rx_byte
  import uart_word_link_pkg::*;
#(
  parameter int DIV        = 434,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rx,
  output logic       byte_ok,
  output logic [7:0] byte_data,
  output logic       parity_bad
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

  logic             sync1, sync2, sync_prev;
  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_sample;
  logic             sample;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign sample = (cnt == LAST_TICK);

  // Start is re-checked half a bit after the falling edge so short glitches are dropped.
  always_comb begin
    state_next = state;
    byte_ok    = 1'b0;
    case (state)
      RX_IDLE:   if (sync_prev && !sync2) state_next = RX_START;
      RX_START:  if (cnt == HALF_LAST) state_next = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (sample && bit_idx == 3'd7) state_next = RX_PARITY;
      RX_PARITY: if (sample) state_next = RX_STOP;
      RX_STOP: begin
        if (sample) begin
          state_next = RX_IDLE;
          byte_ok    = sync2;
        end
      end
      default:   state_next = RX_IDLE;
    endcase
  end

  assign byte_data  = shreg;
  assign parity_bad = parity_bit(shreg, PARITY_ODD) != par_sample;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_sample <= 1'b0;
    end else begin
      state <= state_next;
      if (state == RX_IDLE || state != state_next || sample) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == RX_IDLE) begin
        bit_idx <= '0;
      end
      if (state == RX_DATA && sample) begin
        shreg   <= {sync2, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == RX_PARITY && sample) begin
        par_sample <= sync2;
      end
    end
  end

endmodule

// File: rtl/uart_word_link.sv
// UART word link: sends one 32-bit word as four framed bytes per CLR pulse and
// reassembles received bytes into 32-bit words; also exports the bit-rate clock.
module uart_word_link
  import uart_word_link_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        CLR_Rec,
  input  logic [31:0] Data_Tx,
  input  logic        Rx,
  output logic        Tx,
  output logic        CLK_B,
  output logic [7:0]  Data_Rx,
  output logic        Data_Ready,
  output logic        parity_err,
  output logic [31:0] Final_Data,
  output logic        Final_Data_Ready
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(DIV / 2);
  localparam logic [1:0]       LAST_BYTE = 2'(WORD_BYTES - 1);

  logic [CNT_W-1:0] baud_cnt;

  always_ff @(posedge CLK) begin
    if (CLR || baud_cnt == LAST_TICK) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign CLK_B = (baud_cnt >= HALF_TICK);

  tx_state_t        tx_state, tx_next;
  logic [CNT_W-1:0] tx_tick;
  logic [2:0]       tx_bit;
  logic [1:0]       tx_byte;
  logic [31:0]      tx_word;
  logic [7:0]       tx_cur;
  logic             bit_end;

  assign bit_end = (tx_tick == LAST_TICK);
  assign tx_cur  = tx_word[31:24];

  // IDLE is only ever seen right after reset, so leaving it is the one-shot word load.
  always_comb begin
    tx_next = tx_state;
    Tx      = 1'b1;
    case (tx_state)
      TX_IDLE:  tx_next = TX_START;
      TX_START: begin
        Tx = 1'b0;
        if (bit_end) tx_next = TX_DATA;
      end
      TX_DATA: begin
        Tx = tx_cur[tx_bit];
        if (bit_end && tx_bit == 3'd7) tx_next = TX_PARITY;
      end
      TX_PARITY: begin
        Tx = parity_bit(tx_cur, PARITY_ODD);
        if (bit_end) tx_next = TX_STOP;
      end
      TX_STOP:  if (bit_end) tx_next = (tx_byte == LAST_BYTE) ? TX_DONE : TX_START;
      TX_DONE:  tx_next = TX_DONE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      tx_word  <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE) begin
        tx_word <= Data_Tx;
        tx_tick <= '0;
        tx_bit  <= '0;
        tx_byte <= '0;
      end else if (tx_state != TX_DONE) begin
        tx_tick <= bit_end ? '0 : tx_tick + 1'b1;
        if (bit_end && tx_state == TX_DATA) tx_bit <= tx_bit + 1'b1;
        if (bit_end && tx_state == TX_STOP) begin
          tx_byte <= tx_byte + 1'b1;
          tx_word <= {tx_word[23:0], 8'h00};
        end
      end
    end
  end

  logic        rx_clr;
  logic        byte_ok;
  logic [7:0]  byte_data;
  logic        parity_bad;
  logic [1:0]  byte_cnt;
  logic [31:0] staging;

  assign rx_clr = CLR | CLR_Rec;

  uart_rx_byte #(
    .DIV       (DIV),
    .PARITY_ODD(PARITY_ODD)
  ) u_rx (
    .clk       (CLK),
    .clr       (rx_clr),
    .rx        (Rx),
    .byte_ok   (byte_ok),
    .byte_data (byte_data),
    .parity_bad(parity_bad)
  );

  // Word assembly shares the byte strobe so both ready pulses land in the same cycle.
  always_ff @(posedge CLK) begin
    if (rx_clr) begin
      Data_Rx          <= '0;
      parity_err       <= 1'b0;
      Data_Ready       <= 1'b0;
      Final_Data       <= '0;
      Final_Data_Ready <= 1'b0;
      byte_cnt         <= '0;
      staging          <= '0;
    end else begin
      Data_Ready       <= byte_ok;
      Final_Data_Ready <= byte_ok && (byte_cnt == LAST_BYTE);
      if (byte_ok) begin
        Data_Rx    <= byte_data;
        parity_err <= parity_bad;
        staging    <= {staging[23:0], byte_data};
        byte_cnt   <= byte_cnt + 1'b1;
        if (byte_cnt == LAST_BYTE) begin
          Final_Data <= {staging[23:0], byte_data};
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_word_link.sv
// Self-checking bench for uart_word_link: loopback words, directly driven Rx frames,
// receiver clears and mid-send reset, against a cycle-level model of the line.
module tb_uart_word_link;
  import uart_word_link_pkg::*;

  localparam int CLK_HZ      = 1_600_000;
  localparam int BAUD        = 100_000;
  localparam int DIV         = CLK_HZ / BAUD;
  localparam bit PARITY_ODD  = 1'b0;
  localparam int SEND_BITS   = WORD_BYTES * FRAME_BITS;
  localparam int SEND_CYCLES = SEND_BITS * DIV;

  logic        CLK, CLR, CLR_Rec, Rx, Tx, CLK_B;
  logic [31:0] Data_Tx, Final_Data;
  logic [7:0]  Data_Rx;
  logic        Data_Ready, parity_err, Final_Data_Ready;
  logic        rx_drv, loop_en;

  int checks = 0;
  int failures = 0;

  assign Rx = loop_en ? Tx : rx_drv;

  uart_word_link #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .CLK             (CLK),
    .CLR             (CLR),
    .CLR_Rec         (CLR_Rec),
    .Data_Tx         (Data_Tx),
    .Rx              (Rx),
    .Tx              (Tx),
    .CLK_B           (CLK_B),
    .Data_Rx         (Data_Rx),
    .Data_Ready      (Data_Ready),
    .parity_err      (parity_err),
    .Final_Data      (Final_Data),
    .Final_Data_Ready(Final_Data_Ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic exp_parity(input logic [7:0] b);
    return ((($countones(b) % 2) == 1) ? 1'b1 : 1'b0) ^ PARITY_ODD;
  endfunction

  // Line image of a whole word, bit 0 = first bit on the wire.
  function automatic logic [SEND_BITS-1:0] build_frame(input logic [31:0] w);
    logic [SEND_BITS-1:0] f;
    logic [31:0]          rest;
    logic [7:0]           b;
    logic [10:0]          one;
    f    = '0;
    rest = w;
    for (int i = 0; i < WORD_BYTES; i++) begin
      b    = rest[31:24];
      rest = rest << 8;
      one  = {1'b1, exp_parity(b), b, 1'b0};
      f    = f | (SEND_BITS'(one) << (FRAME_BITS * i));
    end
    return f;
  endfunction

  logic                 model_on = 1'b0;
  logic                 armed = 1'b0;
  int                   cb_model = 0;
  int                   tx_pos = -1;
  logic [SEND_BITS-1:0] frame = '0;
  logic [SEND_BITS-1:0] frame_sh;
  logic                 exp_tx;
  int                   tx_err = 0;
  int                   cb_err = 0;
  int                   pulse_err = 0;
  int                   sync_err = 0;
  logic                 dr_prev = 1'b0;
  logic [8:0]           byte_q[$];
  logic [31:0]          word_q[$];

  always @(posedge CLK) begin
    if (CLR) begin
      model_on <= 1'b1;
      cb_model <= 0;
      armed    <= 1'b1;
      tx_pos   <= -1;
    end else begin
      cb_model <= (cb_model + 1) % DIV;
      if (armed) begin
        armed  <= 1'b0;
        frame  <= build_frame(Data_Tx);
        tx_pos <= 0;
      end else if (tx_pos >= 0 && tx_pos < SEND_CYCLES) begin
        tx_pos <= tx_pos + 1;
      end
    end
  end

  always_comb begin
    frame_sh = '0;
    exp_tx   = 1'b1;
    if (tx_pos >= 0 && tx_pos < SEND_CYCLES) begin
      frame_sh = frame >> (tx_pos / DIV);
      exp_tx   = frame_sh[0];
    end
  end

  always @(negedge CLK) begin
    if (model_on) begin
      if (Tx !== exp_tx) tx_err <= tx_err + 1;
      if (CLK_B !== (cb_model >= DIV / 2)) cb_err <= cb_err + 1;
      if (Data_Ready === 1'b1 && dr_prev) pulse_err <= pulse_err + 1;
      if (Final_Data_Ready === 1'b1 && Data_Ready !== 1'b1) sync_err <= sync_err + 1;
      if (Data_Ready === 1'b1) byte_q.push_back({parity_err, Data_Rx});
      if (Final_Data_Ready === 1'b1) word_q.push_back(Final_Data);
      dr_prev <= (Data_Ready === 1'b1);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
    logic [10:0] bits;
    bits = {stop_bit, exp_parity(b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) begin
      rx_drv = bits[0];
      bits   = bits >> 1;
      repeat (DIV) @(negedge CLK);
    end
    rx_drv = 1'b1;
    repeat (2 * DIV) @(negedge CLK);
  endtask

  task automatic wait_word(input int budget, output int used);
    used = 0;
    while (word_q.size() == 0 && used < budget) begin
      @(posedge CLK);
      used++;
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] w);
    check_output({tag, "_count"}, 32'(word_q.size()), 32'd1);
    check_output(tag, (word_q.size() > 0) ? word_q[0] : 32'hxxxx_xxxx, w);
  endtask

  task automatic run_word(input logic [31:0] w);
    int used;
    @(negedge CLK);
    loop_en = 1'b1;
    Data_Tx = w;
    CLR     = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    byte_q.delete();
    word_q.delete();
    check_output("idle_before_start", 32'(Tx), 32'd1);
    @(posedge CLK);
    #1;
    check_output("start_bit", 32'(Tx), 32'd0);
    @(negedge CLK);
    Data_Tx = ~w;
    wait_word(SEND_CYCLES + 2 * DIV - 3, used);
    check_output("word_in_time", 32'(word_q.size() > 0), 32'd1);
    check_word("loop_word", w);
    check_output("loop_byte_count", 32'(byte_q.size()), 32'd4);
    for (int i = 0; i < WORD_BYTES; i++) begin
      check_output("loop_byte", (i < byte_q.size()) ? 32'(byte_q[i]) : 32'hxxxx_xxxx,
                   (w >> (24 - 8 * i)) & 32'hFF);
    end
    check_output("final_data_held", Final_Data, w);
    repeat (2 * DIV) @(negedge CLK);
    check_output("tx_idle_after", 32'(Tx), 32'd1);
  endtask

  logic [7:0]  r1, r2, r3;
  logic [31:0] w1, w2;
  int          used, rise1, rise2;
  logic        prev_cb;

  initial begin
    CLR     = 1'b1;
    CLR_Rec = 1'b0;
    Data_Tx = '0;
    rx_drv  = 1'b1;
    loop_en = 1'b0;
    repeat (3) @(negedge CLK);
    check_output("rst_tx", 32'(Tx), 32'd1);
    check_output("rst_clk_b", 32'(CLK_B), 32'd0);
    check_output("rst_data_rx", 32'(Data_Rx), 32'd0);
    check_output("rst_data_ready", 32'(Data_Ready), 32'd0);
    check_output("rst_parity_err", 32'(parity_err), 32'd0);
    check_output("rst_final_data", Final_Data, 32'd0);
    check_output("rst_final_ready", 32'(Final_Data_Ready), 32'd0);

    $display("[TB] loopback words");
    run_word(32'hABACADAE);
    run_word(32'hABACADAF);
    repeat (3) run_word($urandom);

    $display("[TB] directly driven Rx frames");
    @(negedge CLK);
    loop_en = 1'b0;
    CLR_Rec = 1'b1;
    @(negedge CLK);
    CLR_Rec = 1'b0;
    byte_q.delete();
    word_q.delete();
    check_output("clr_rec_data_rx", 32'(Data_Rx), 32'd0);
    check_output("clr_rec_final", Final_Data, 32'd0);
    check_output("clr_rec_tx_idle", 32'(Tx), 32'd1);
    drive_frame(8'h55, 1'b1, 1'b1);
    check_output("bad_parity_byte", (byte_q.size() > 0) ? 32'(byte_q[0]) : 32'hxxxx_xxxx,
                 32'h155);
    check_output("bad_parity_flag", 32'(parity_err), 32'd1);
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    r3 = 8'($urandom);
    drive_frame(r1, 1'b0, 1'b1);
    drive_frame(r2, 1'b0, 1'b1);
    drive_frame(r3, 1'b0, 1'b1);
    check_word("bad_parity_word", {8'h55, r1, r2, r3});
    check_output("parity_err_cleared", 32'(parity_err), 32'd0);

    byte_q.delete();
    word_q.delete();
    drive_frame(8'h99, 1'b0, 1'b0);
    check_output("framing_no_ready", 32'(byte_q.size()), 32'd0);
    check_output("framing_data_kept", 32'(Data_Rx), 32'(r3));
    drive_frame(8'h11, 1'b0, 1'b1);
    drive_frame(8'h22, 1'b0, 1'b1);
    drive_frame(8'h33, 1'b0, 1'b1);
    drive_frame(8'h44, 1'b0, 1'b1);
    check_word("after_framing_word", 32'h11223344);

    $display("[TB] receiver clear during a send");
    @(negedge CLK);
    Data_Tx = $urandom;
    CLR     = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    byte_q.delete();
    word_q.delete();
    drive_frame(8'($urandom), 1'b0, 1'b1);
    drive_frame(8'($urandom), 1'b0, 1'b1);
    CLR_Rec = 1'b1;
    @(negedge CLK);
    CLR_Rec = 1'b0;
    check_output("clr_rec2_data_rx", 32'(Data_Rx), 32'd0);
    check_output("clr_rec2_parity", 32'(parity_err), 32'd0);
    drive_frame(8'h01, 1'b0, 1'b1);
    drive_frame(8'h02, 1'b0, 1'b1);
    drive_frame(8'h03, 1'b0, 1'b1);
    drive_frame(8'h04, 1'b0, 1'b1);
    check_word("clr_rec_word", 32'h01020304);
    check_output("tx_during_clr_rec", 32'(tx_err), 32'd0);

    $display("[TB] reset in the middle of a send");
    w1 = $urandom;
    w2 = $urandom;
    @(negedge CLK);
    loop_en = 1'b1;
    Data_Tx = w1;
    CLR     = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    repeat (15 * DIV + DIV / 3) @(negedge CLK);
    check_output("partial_byte_seen", 32'(Data_Rx), 32'(w1 >> 24));
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    check_output("midrst_tx", 32'(Tx), 32'd1);
    check_output("midrst_clk_b", 32'(CLK_B), 32'd0);
    check_output("midrst_data_rx", 32'(Data_Rx), 32'd0);
    check_output("midrst_data_ready", 32'(Data_Ready), 32'd0);
    check_output("midrst_parity", 32'(parity_err), 32'd0);
    check_output("midrst_final", Final_Data, 32'd0);
    check_output("midrst_final_ready", 32'(Final_Data_Ready), 32'd0);
    @(negedge CLK);
    Data_Tx = w2;
    CLR     = 1'b0;
    byte_q.delete();
    word_q.delete();
    rise1   = -1;
    rise2   = -1;
    prev_cb = CLK_B;
    for (int c = 1; c <= 3 * DIV && rise2 < 0; c++) begin
      @(posedge CLK);
      #1;
      if (CLK_B && !prev_cb) begin
        if (rise1 < 0) rise1 = c;
        else rise2 = c;
      end
      prev_cb = CLK_B;
    end
    check_output("clk_b_first_rise", 32'(rise1), 32'(DIV / 2));
    check_output("clk_b_period", 32'(rise2 - rise1), 32'(DIV));
    wait_word(SEND_CYCLES + DIV, used);
    check_word("after_midrst_word", w2);

    check_output("tx_waveform", 32'(tx_err), 32'd0);
    check_output("clk_b_waveform", 32'(cb_err), 32'd0);
    check_output("ready_pulse_width", 32'(pulse_err), 32'd0);
    check_output("final_ready_sync", 32'(sync_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
